// File: rtl/mul2x2_seq_ctrl_if.sv
// Bundle for the mul2x2_seq_ctrl controller: the operand handshake, the result
// handshake, the 2x2 partial-product unit connection and the busy flag.
//   master : operand source, result sink and 2x2 unit (drive in_valid, a, b,
//            out_ready and pp_res)
//   slave  : the controller (drives in_ready, pp_a, pp_b, out_valid, product
//            and busy)
// Parameter WIDTH is the operand width and must match the controller's WIDTH.
interface mul2x2_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           pp_a;
  logic [1:0]           pp_b;
  logic [3:0]           pp_res;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, pp_res, out_ready,
    input  in_ready, pp_a, pp_b, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, pp_res, out_ready,
    output in_ready, pp_a, pp_b, out_valid, product, busy
  );
endinterface

// File: rtl/mul2x2_seq_ctrl.sv
// Iterative WIDTH x WIDTH unsigned multiplier controller. It time-shares one
// external combinational 2x2 partial-product unit. The controller steps over
// every pair of 2-bit operand digits (i outer, j inner). It accumulates each
// 4-bit partial product at weight 4^(i+j).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - mul2x2_seq_ctrl_if.slave:
//          operand handshake (in_valid/in_ready, a, b),
//          result handshake (out_valid/out_ready, product),
//          2x2 unit connection (pp_a, pp_b out; pp_res in, same-cycle),
//          busy (high while iterating).
// Optional feature: define ZERO_SKIP_EN to complete a zero operand pair
// directly (IDLE -> DONE, product 0) without iterating.
module mul2x2_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  mul2x2_seq_ctrl_if.slave bus
);
  localparam int unsigned D  = WIDTH / 2;
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [IW-1:0] DLAST = IW'(D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_nxt;
  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic [IW-1:0]   i_nxt;
  logic [IW-1:0]   j_nxt;
  logic [IW+1:0]   shamt;
  logic            last;

  always_comb begin
    last  = (i == DLAST) && (j == DLAST);
    i_nxt = i;
    j_nxt = j + IW'(1);
    if (j == DLAST) begin
      j_nxt = '0;
      i_nxt = i + IW'(1);
    end
    shamt   = ({2'b00, i} + {2'b00, j}) << 1;
    acc_nxt = acc + (PW'(bus.pp_res) << shamt);
  end

  // The digit outputs are registered. They are preloaded with digit 0 on
  // accept, then with the next step's digits each cycle, so that the 2x2 unit
  // always sees the digits that belong to the current (i, j).
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.product   <= '0;
      bus.pp_a      <= '0;
      bus.pp_b      <= '0;
      acc           <= '0;
      i             <= '0;
      j             <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q          <= bus.a;
            b_q          <= bus.b;
            acc          <= '0;
            i            <= '0;
            j            <= '0;
            bus.in_ready <= 1'b0;
`ifdef ZERO_SKIP_EN
            if (bus.a == '0 || bus.b == '0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.product   <= '0;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
              bus.pp_a <= bus.a[1:0];
              bus.pp_b <= bus.b[1:0];
            end
`else
            state    <= RUN;
            bus.busy <= 1'b1;
            bus.pp_a <= bus.a[1:0];
            bus.pp_b <= bus.b[1:0];
`endif
          end
        end
        RUN: begin
          acc <= acc_nxt;
          i   <= i_nxt;
          j   <= j_nxt;
          if (last) begin
            state         <= DONE;
            bus.product   <= acc_nxt;
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
            bus.pp_a      <= '0;
            bus.pp_b      <= '0;
          end else begin
            bus.pp_a <= a_q[2*i_nxt +: 2];
            bus.pp_b <= b_q[2*j_nxt +: 2];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul2x2_seq_ctrl.sv
module tb_mul2x2_seq_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned D     = WIDTH / 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [2*WIDTH-1:0] sb[$];

  mul2x2_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul2x2_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 2x2 partial-product unit.
  assign bus.pp_res = {2'b00, bus.pp_a} * {2'b00, bus.pp_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: pop on every result handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check_eq("unexpected_result", 32'(bus.product), 32'hDEAD);
      else check_eq("product", 32'(bus.product), 32'(sb.pop_front()));
    end
  end

  function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef ZERO_SKIP_EN
    if (a == '0 || b == '0) return 0;
`endif
    return D * D;
  endfunction

  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit hold, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
    int n;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("accept_timeout", 32'(n), 0);
    sb.push_back((2*WIDTH)'(a) * (2*WIDTH)'(b));
    @(posedge clk);
    #1;
    if (hold) begin
      bus.a = na;
      bus.b = nb;
    end else begin
      bus.in_valid = 1'b0;
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
    end
  endtask

  task automatic wait_done(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int stall);
    int n;
    logic [2*WIDTH-1:0] exp;
    exp = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      check_eq("pp_a", 32'(bus.pp_a), 32'((a >> (2 * (n / D))) & 3));
      check_eq("pp_b", 32'(bus.pp_b), 32'((b >> (2 * (n % D))) & 3));
      check_eq("busy_run", 32'(bus.busy), 1);
      check_eq("in_ready_run", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'(exp_latency(a, b)));
    check_eq("busy_done", 32'(bus.busy), 0);
    for (int s = 0; s < stall; s++) begin
      check_eq("hold_valid", 32'(bus.out_valid), 1);
      check_eq("hold_product", 32'(bus.product), 32'(exp));
      check_eq("hold_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("valid_drop", 32'(bus.out_valid), 0);
    check_eq("in_ready_idle", 32'(bus.in_ready), 1);
    check_eq("product_kept", 32'(bus.product), 32'(exp));
    check_eq("pp_idle", 32'({bus.pp_a, bus.pp_b}), 0);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int stall,
                       input bit hold, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
    bus.out_ready = (stall == 0);
    accept_op(a, b, hold, na, nb);
    wait_done(a, b, stall);
  endtask

  initial begin
    bit saw_valid;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(bus.in_ready), 1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_product", 32'(bus.product), 0);
    check_eq("rst_pp", 32'({bus.pp_a, bus.pp_b}), 0);

    do_op(8'd13, 8'd11, 0, 1'b0, '0, '0);
    do_op(8'hFF, 8'hFF, 0, 1'b0, '0, '0);
    do_op(8'd200, 8'd3, 10, 1'b0, '0, '0);

    // Abort mid-run: the partial result must never appear.
    bus.out_ready = 1'b1;
    accept_op(8'h3C, 8'h5A, 1'b0, '0, '0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check_eq("abort_in_ready", 32'(bus.in_ready), 1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 0);
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_product", 32'(bus.product), 0);
    check_eq("abort_pp", 32'({bus.pp_a, bus.pp_b}), 0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check_eq("abort_no_valid", 32'(saw_valid), 0);
    do_op(8'd5, 8'd6, 0, 1'b0, '0, '0);

    do_op(8'h00, 8'h9A, 0, 1'b0, '0, '0);

    do_op(8'd7, 8'd9, 0, 1'b1, 8'h80, 8'h02);
    do_op(8'h80, 8'h02, 0, 1'b0, '0, '0);

    for (int k = 0; k < 4; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
